// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr block and its command sequencer.
// Holds the sequencer state encoding, default widths and the feedback tap table.
package lfsr_pkg;

  localparam int unsigned LFSR_N_DEFAULT  = 4;
  localparam int unsigned LFSR_CW_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } lfsr_seq_state_t;

  // Maximal-length tap masks for a left-shifting Fibonacci LFSR
  function automatic logic [31:0] lfsr_taps(input int unsigned n);
    logic [31:0] taps;
    case (n)
      3:       taps = 32'h0000_0006;
      4:       taps = 32'h0000_000C;
      5:       taps = 32'h0000_0014;
      6:       taps = 32'h0000_0030;
      7:       taps = 32'h0000_0060;
      8:       taps = 32'h0000_00B8;
      default: taps = 32'h0000_000C;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR with a synchronous seed load.
// Advances every cycle that load_seed is low; a zero seed would lock it at zero.
module lfsr
  import lfsr_pkg::*;
#(
  parameter int unsigned N = LFSR_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_seed,
  input  logic [N-1:0] seed_data,
  output logic [N-1:0] lfsr_data
);

  localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

  logic feedback_c;

  assign feedback_c = ^(lfsr_data & TAPS);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_data <= N'(1);
    end else if (load_seed) begin
      lfsr_data <= seed_data;
    end else begin
      lfsr_data <= {lfsr_data[N-2:0], feedback_c};
    end
  end

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer for the lfsr: loads a seed, lets the lfsr advance a fixed
// number of steps, then returns the resulting word with wrap and error flags.
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned N  = LFSR_N_DEFAULT,
  parameter int unsigned CW = LFSR_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_seed,
  input  logic [CW-1:0] cmd_steps,
  output logic          load_seed,
  output logic [N-1:0]  seed_data,
  input  logic [N-1:0]  lfsr_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  rsp_data,
  output logic          rsp_wrapped,
  output logic          rsp_err,
  output logic          busy
);

  lfsr_seq_state_t state;
  lfsr_seq_state_t state_d;

  logic [CW-1:0] steps_q;
  logic [CW-1:0] cnt_q;
  logic          wrap_q;
  logic          first_q;

  logic [N-1:0]  seed_data_d;
  logic [CW-1:0] steps_d;
  logic [CW-1:0] cnt_d;
  logic          wrap_d;
  logic          first_d;
  logic [N-1:0]  rsp_data_d;
  logic          rsp_wrapped_d;
  logic          rsp_err_d;

  logic accept_c;
  logic seed_zero_c;
  logic hit_c;

  assign accept_c    = cmd_valid && cmd_ready;
  assign seed_zero_c = (cmd_seed == '0);
  // The first RUN cycle always shows the seed just loaded, so it never counts as a wrap
  assign hit_c       = !first_q && (lfsr_data == seed_data);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_d = seed_zero_c ? RESP : LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result next values
  always_comb begin
    seed_data_d   = seed_data;
    steps_d       = steps_q;
    cnt_d         = cnt_q;
    wrap_d        = wrap_q;
    first_d       = first_q;
    rsp_data_d    = rsp_data;
    rsp_wrapped_d = rsp_wrapped;
    rsp_err_d     = rsp_err;
    case (state)
      IDLE: begin
        if (accept_c) begin
          seed_data_d   = cmd_seed;
          steps_d       = cmd_steps;
          rsp_data_d    = '0;
          rsp_wrapped_d = 1'b0;
          rsp_err_d     = seed_zero_c;
        end
      end
      LOAD: begin
        cnt_d   = steps_q;
        wrap_d  = 1'b0;
        first_d = 1'b1;
      end
      RUN: begin
        first_d = 1'b0;
        if (hit_c) begin
          wrap_d = 1'b1;
        end
        if (cnt_q == '0) begin
          rsp_data_d    = lfsr_data;
          rsp_wrapped_d = wrap_q || hit_c;
          rsp_err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Registered outputs derived from the upcoming state, plus datapath storage
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      load_seed   <= 1'b0;
      rsp_valid   <= 1'b0;
      seed_data   <= '0;
      steps_q     <= '0;
      cnt_q       <= '0;
      wrap_q      <= 1'b0;
      first_q     <= 1'b0;
      rsp_data    <= '0;
      rsp_wrapped <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      cmd_ready   <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      load_seed   <= (state_d == LOAD);
      rsp_valid   <= (state_d == RESP);
      seed_data   <= seed_data_d;
      steps_q     <= steps_d;
      cnt_q       <= cnt_d;
      wrap_q      <= wrap_d;
      first_q     <= first_d;
      rsp_data    <= rsp_data_d;
      rsp_wrapped <= rsp_wrapped_d;
      rsp_err     <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl driving a 4-bit maximal-length lfsr (period 15).
module tb_lfsr_seq_ctrl;
  import lfsr_pkg::*;

  localparam int unsigned N  = LFSR_N_DEFAULT;
  localparam int unsigned CW = LFSR_CW_DEFAULT;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_seed;
  logic [CW-1:0] cmd_steps;
  logic          load_seed;
  logic [N-1:0]  seed_data;
  logic [N-1:0]  lfsr_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_data;
  logic          rsp_wrapped;
  logic          rsp_err;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr #(.N(N)) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .load_seed (load_seed),
    .seed_data (seed_data),
    .lfsr_data (lfsr_data)
  );

  lfsr_seq_ctrl #(.N(N), .CW(CW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_seed    (cmd_seed),
    .cmd_steps   (cmd_steps),
    .load_seed   (load_seed),
    .seed_data   (seed_data),
    .lfsr_data   (lfsr_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_wrapped (rsp_wrapped),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers a command, then follows it until rsp_valid; lat is k for rsp_valid at T+k
  task automatic issue_cmd(input logic [N-1:0] seed, input logic [CW-1:0] steps,
                           output int lat, output int loads, output int load_at,
                           output logic [N-1:0] data, output logic wr, output logic er);
    int guard;
    guard = 0;
    cmd_seed  = seed;
    cmd_steps = steps;
    cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    cmd_valid = 1'b0;
    cmd_seed  = N'($urandom);
    cmd_steps = CW'($urandom);
    lat = -1;
    loads = 0;
    load_at = -1;
    for (int k = 1; k <= 200; k++) begin
      if (load_seed === 1'b1) begin
        loads++;
        if (load_at < 0) load_at = k;
      end
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    data = rsp_data;
    wr   = rsp_wrapped;
    er   = rsp_err;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_seed = '0;
    cmd_steps = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (load_seed !== 1'b0) begin miscompares++; $display("FAIL reset_load_seed got=%b exp=0", load_seed); end
    vectors++; if (seed_data !== 4'b0000) begin miscompares++; $display("FAIL reset_seed_data got=%b exp=0000", seed_data); end
    vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    vectors++; if (rsp_data !== 4'b0000) begin miscompares++; $display("FAIL reset_rsp_data got=%b exp=0000", rsp_data); end
    vectors++; if (rsp_wrapped !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_wrapped got=%b exp=0", rsp_wrapped); end
    vectors++; if (rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
  endtask

  task automatic test_steps_zero();
    int lat, loads, load_at;
    logic [N-1:0] d;
    logic w, e;
    issue_cmd(4'b1111, 16'd0, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL s0_latency got=%0d exp=3", lat); end
    vectors++; if (loads !== 1 || load_at !== 1) begin miscompares++; $display("FAIL s0_load_pulse got=%0d@%0d exp=1@1", loads, load_at); end
    vectors++; if (d !== 4'b1111) begin miscompares++; $display("FAIL s0_data got=%b exp=1111", d); end
    vectors++; if (w !== 1'b0 || e !== 1'b0) begin miscompares++; $display("FAIL s0_flags got=%b%b exp=00", w, e); end
    vectors++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin miscompares++; $display("FAIL s0_resp_status got=%b%b exp=10", busy, cmd_ready); end
    consume();
    vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL s0_back_idle got=%b%b%b exp=010", rsp_valid, cmd_ready, busy); end
  endtask

  task automatic test_wrap();
    int lat, loads, load_at;
    logic [N-1:0] d;
    logic w, e;
    issue_cmd(4'b1111, 16'd15, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 18) begin miscompares++; $display("FAIL w15_latency got=%0d exp=18", lat); end
    vectors++; if (d !== 4'b1111 || w !== 1'b1 || e !== 1'b0) begin miscompares++; $display("FAIL w15_result got=%b w=%b e=%b exp=1111 w=1 e=0", d, w, e); end
    consume();
    issue_cmd(4'b1111, 16'd14, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 17) begin miscompares++; $display("FAIL w14_latency got=%0d exp=17", lat); end
    vectors++; if (d !== 4'b0111 || w !== 1'b0) begin miscompares++; $display("FAIL w14_result got=%b w=%b exp=0111 w=0", d, w); end
    consume();
    issue_cmd(4'b0001, 16'd3, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 6 || d !== 4'b1001 || w !== 1'b0) begin miscompares++; $display("FAIL s3_result got=%0d/%b/%b exp=6/1001/0", lat, d, w); end
    consume();
    issue_cmd(4'b1111, 16'd20, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 23 || d !== 4'b0010 || w !== 1'b1) begin miscompares++; $display("FAIL s20_result got=%0d/%b/%b exp=23/0010/1", lat, d, w); end
    consume();
  endtask

  task automatic test_zero_seed();
    int lat, loads, load_at;
    logic [N-1:0] d;
    logic w, e;
    issue_cmd(4'b0000, 16'd5, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL zs_latency got=%0d exp=1", lat); end
    vectors++; if (loads !== 0) begin miscompares++; $display("FAIL zs_no_load got=%0d exp=0", loads); end
    vectors++; if (e !== 1'b1 || d !== 4'b0000 || w !== 1'b0) begin miscompares++; $display("FAIL zs_result got=e%b d%b w%b exp=e1 d0000 w0", e, d, w); end
    consume();
    vectors++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL zs_back_idle got=%b%b exp=01", rsp_valid, cmd_ready); end
  endtask

  task automatic test_back_to_back();
    int lat, loads, load_at;
    int bad;
    logic [N-1:0] d;
    logic w, e;
    issue_cmd(4'b0101, 16'd2, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 5 || d !== 4'b0111) begin miscompares++; $display("FAIL bb_first got=%0d/%b exp=5/0111", lat, d); end
    cmd_seed  = 4'b1000;
    cmd_steps = 16'd1;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || rsp_data !== 4'b0111 || cmd_ready !== 1'b0 || load_seed !== 1'b0) bad++;
    end
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL bb_stall_stable got=%0d bad cycles exp=0", bad); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    vectors++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin miscompares++; $display("FAIL bb_idle_after_hs got=%b%b exp=10", cmd_ready, rsp_valid); end
    tick();
    cmd_valid = 1'b0;
    cmd_seed  = 4'b0011;
    vectors++; if (load_seed !== 1'b1 || seed_data !== 4'b1000) begin miscompares++; $display("FAIL bb_accept got=%b/%b exp=1/1000", load_seed, seed_data); end
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid === 1'b1) begin
        lat = k;
        break;
      end
      tick();
    end
    vectors++; if (lat !== 4 || rsp_data !== 4'b0001 || rsp_wrapped !== 1'b0) begin miscompares++; $display("FAIL bb_second got=%0d/%b/%b exp=4/0001/0", lat, rsp_data, rsp_wrapped); end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int lat, loads, load_at, seen;
    logic [N-1:0] d;
    logic w, e;
    cmd_seed  = 4'b1010;
    cmd_steps = 16'd100;
    cmd_valid = 1'b1;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mr_ready got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || load_seed !== 1'b0 || cmd_ready !== 1'b1) begin miscompares++; $display("FAIL mr_idle got=v%b b%b l%b r%b exp=v0 b0 l0 r1", rsp_valid, busy, load_seed, cmd_ready); end
    vectors++; if (rsp_err !== 1'b0 || rsp_wrapped !== 1'b0) begin miscompares++; $display("FAIL mr_flags got=%b%b exp=00", rsp_err, rsp_wrapped); end
    seen = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL mr_no_response got=%0d active cycles exp=0", seen); end
    issue_cmd(4'b1111, 16'd0, lat, loads, load_at, d, w, e);
    vectors++; if (lat !== 3 || d !== 4'b1111 || w !== 1'b0 || e !== 1'b0) begin miscompares++; $display("FAIL mr_next_cmd got=%0d/%b/%b%b exp=3/1111/00", lat, d, w, e); end
    consume();
  endtask

  initial begin
    test_reset();
    test_steps_zero();
    test_wrap();
    test_zero_seed();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
